munoc_moi_request_arbiter: RTL
==============================

# munoc_moi_request_arbiter

Shares one MOI (memory-order interface) master port of the MUNoC master network interface between NUM_REQ local requesters. Sits between local masters and the network interface's rlmq/rlmy port. Arbitrates requests round-robin and records the requester index of every read in an in-order FIFO. Read responses arrive in request order, so each one is routed back to the recorded requester.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- BW_PLATFORM_ADDR, 32: address width.
- BW_NODE_DATA, 32: data width; BW_PERMIT = ceil(BW_NODE_DATA/8).
- BW_BURDEN_NZ, 1: per-request burden width, passed through unchanged.
- MAX_OUTSTANDING, 4: read responses that may be pending (power of two, ≥2).

Ports (vector fields are packed as requester i at slice i):
- clk  in  1  clock.
- rstnn  in  1  asynchronous, active-low reset.
- sqvalid  in  NUM_REQ  request valid per requester.
- sqdready  out  2*NUM_REQ  request ready per requester.
- sqaddr / sqwrite / sqwdata / sqwpermit / sqburden  in  NUM_REQ × field width  request fields.
- sydready  in  2*NUM_REQ  response ready per requester.
- syvalid  out  NUM_REQ  response valid per requester.
- syrdata / syburden  out  BW_NODE_DATA / BW_BURDEN_NZ  response fields, shared by all requesters.
- mqdready  in  2  downstream request ready.
- mqvalid, mqaddr, mqwrite, mqwdata, mqwpermit, mqburden  out  request to the NI.
- mydready  out  2  response ready to the NI.
- myvalid, myrdata, myburden  in  response from the NI.
- outstanding  out  clog2(MAX_OUTSTANDING)+1  number of pending reads.

## Operation
- **Transfer rules.** A request transfers when valid & dready[0]. A response transfers when myvalid & mydready[0]. dready[1] is forwarded unmodified on the selected path.
- **Arbitration.** Round-robin pointer ptr, 0..NUM_REQ-1. The winner is the first asserted sqvalid found searching from ptr upward, wrapping around.
- **Grant qualification.** A grant is allowed only when both hold:
  - no write is stalled mid-transfer (see hold rule);
  - the winner is writing (sqwrite=1), or the FIFO is not full.
- **Request mux.** The winner's fields are muxed combinationally onto mq*. mqvalid = winner exists & grant allowed. sqdready[winner] = mqdready. All other sqdready = 0.
- **Pointer update.** On request transfer, ptr <= winner+1 mod NUM_REQ. With no transfer, ptr holds.
- **Hold rule.** A winner whose request is presented but not accepted keeps the grant until it transfers. No re-arbitration happens while mqvalid & ~mqdready[0].
- **Order FIFO push.** On a read request transfer (mqwrite=0), the winner index is pushed. Writes produce no response and are not tracked.
- **Response routing.** Head index h. When the FIFO is non-empty:
  - syvalid[h] = myvalid; all other syvalid = 0;
  - mydready = sydready[h];
  - syrdata/syburden = myrdata/myburden.
  When the FIFO is empty, mydready = 0 and syvalid = 0.
- **FIFO pop.** Pop on response transfer. A push and pop in the same cycle leave `outstanding` unchanged.
- **Read from a full FIFO.** The winning requester is stalled: it is not granted, and sqdready = 0. Round-robin still holds for it, so a later writer elsewhere is not skipped past it.
- **Unexpected response.** myvalid while the FIFO is empty is ignored (mydready = 0). In simulation it is flagged with $display.

## Timing
- Request path is zero-latency combinational, valid-to-mqvalid and mqdready-to-sqdready. No registers are in the data path.
- Response path is zero-latency combinational.
- The FIFO and ptr update on the clk rising edge after the transfer. A push in cycle n makes the entry poppable in cycle n+1.
- Reset values: ptr = 0, FIFO empty, outstanding = 0. All outputs derive from these: mqvalid = 0 unless a requester is valid, and mydready = 0, syvalid = 0.
- A reset asserted mid-operation discards all pending read indices. Responses arriving afterwards are ignored as unexpected.

## Configuration
- MUNOC_MOI_ARB_PRIORITY_EN defined: requester 0 has fixed highest priority. If sqvalid[0] is set and grant is allowed for it, it wins regardless of ptr. Its grant does not advance ptr. The other requesters rotate round-robin among themselves.
- Not defined: pure round-robin as described in Operation.

## Structure
- The shared package munoc_moi_arb_pkg holds:
  - localparams BW_REQ_IDX = clog2(NUM_REQ) and BW_OUTSTANDING;
  - the round-robin next-pointer function.
- One sub-module, munoc_moi_order_fifo: a synchronous FIFO of width BW_REQ_IDX and depth MAX_OUTSTANDING, with push/pop/full/empty/count ports and asynchronous active-low reset on rstnn.

## Test plan
- **Round-robin.** All 4 requesters reading continuously, mqdready = 2'b11, responses returned one cycle later. Grant order must be 0,1,2,3,0.
- **Response routing.** Reads from requesters 2 then 0, with response data 0xAAAA then 0x5555. syvalid[2] with 0xAAAA, then syvalid[0] with 0x5555.
- **Full FIFO.** Issue 4 reads with no responses → outstanding = 4. A 5th read from requester 1 sees sqdready = 0. A write from requester 3 in the same period is granted.
- **Backpressure hold.** mqdready = 0 for 3 cycles with requesters 1 and 2 valid. The grant stays on 1 and mqaddr is stable. After mqdready rises, 1 transfers, then 2.
- **Simultaneous push/pop.** A read transfer and a response transfer in the same cycle with outstanding = 2. outstanding remains 2.
- **Reset mid-operation.** Assert rstnn = 0 with outstanding = 3. Next cycle outstanding = 0. A following myvalid sees mydready = 0.

Source files
------------

// File: rtl/munoc_moi_arb_pkg.sv
// Shared widths and round-robin helper for the MOI request arbiter.
// Default sizes here match the default parameters of munoc_moi_request_arbiter.
package munoc_moi_arb_pkg;

   localparam int unsigned NUM_REQ_DEF         = 4;
   localparam int unsigned MAX_OUTSTANDING_DEF = 4;
   localparam int unsigned BW_REQ_IDX          = $clog2(NUM_REQ_DEF);
   localparam int unsigned BW_OUTSTANDING      = $clog2(MAX_OUTSTANDING_DEF) + 1;
   localparam int unsigned BW_PTR_MAX          = 3;

   // Pointer to the requester after idx, wrapping at num (num <= 8).
   function automatic logic [BW_PTR_MAX-1:0] rr_next_ptr(input logic [BW_PTR_MAX-1:0] idx,
                                                         input int unsigned num);
      if (32'(idx) + 32'd1 >= num) return '0;
      return idx + 3'd1;
   endfunction

endpackage

// File: rtl/munoc_moi_order_fifo.sv
// In-order FIFO of requester indices for reads still awaiting a response.
module munoc_moi_order_fifo
#(
   parameter int unsigned WIDTH = 2,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rstnn,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned BW_PTR = $clog2(DEPTH);
   localparam int unsigned BW_CNT = BW_PTR + 1;

   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic [WIDTH-1:0]  mem_d [DEPTH];
   logic [BW_PTR-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [BW_CNT-1:0] count_q, count_d;
   logic              do_push, do_pop;

   always_comb begin
      full     = (count_q == BW_CNT'(DEPTH));
      empty    = (count_q == '0);
      do_push  = push & ~full;
      do_pop   = pop & ~empty;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + BW_PTR'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + BW_PTR'(1);
      count_d  = count_q + BW_CNT'(do_push) - BW_CNT'(do_pop);
      head     = mem_q[rd_ptr_q];
      count    = count_q;
   end

   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/munoc_moi_request_arbiter.sv
// Shares one MOI master port among NUM_REQ requesters; read responses routed back in order.
// Define MUNOC_MOI_ARB_PRIORITY_EN to give requester 0 fixed highest priority.
module munoc_moi_request_arbiter
   import munoc_moi_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ          = NUM_REQ_DEF,
   parameter int unsigned BW_PLATFORM_ADDR = 32,
   parameter int unsigned BW_NODE_DATA     = 32,
   parameter int unsigned BW_BURDEN_NZ     = 1,
   parameter int unsigned MAX_OUTSTANDING  = MAX_OUTSTANDING_DEF
) (
   input  logic                                     clk,
   input  logic                                     rstnn,
   input  logic [NUM_REQ-1:0]                       sqvalid,
   output logic [2*NUM_REQ-1:0]                     sqdready,
   input  logic [NUM_REQ*BW_PLATFORM_ADDR-1:0]      sqaddr,
   input  logic [NUM_REQ-1:0]                       sqwrite,
   input  logic [NUM_REQ*BW_NODE_DATA-1:0]          sqwdata,
   input  logic [NUM_REQ*((BW_NODE_DATA+7)/8)-1:0]  sqwpermit,
   input  logic [NUM_REQ*BW_BURDEN_NZ-1:0]          sqburden,
   input  logic [2*NUM_REQ-1:0]                     sydready,
   output logic [NUM_REQ-1:0]                       syvalid,
   output logic [BW_NODE_DATA-1:0]                  syrdata,
   output logic [BW_BURDEN_NZ-1:0]                  syburden,
   input  logic [1:0]                               mqdready,
   output logic                                     mqvalid,
   output logic [BW_PLATFORM_ADDR-1:0]              mqaddr,
   output logic                                     mqwrite,
   output logic [BW_NODE_DATA-1:0]                  mqwdata,
   output logic [((BW_NODE_DATA+7)/8)-1:0]          mqwpermit,
   output logic [BW_BURDEN_NZ-1:0]                  mqburden,
   output logic [1:0]                               mydready,
   input  logic                                     myvalid,
   input  logic [BW_NODE_DATA-1:0]                  myrdata,
   input  logic [BW_BURDEN_NZ-1:0]                  myburden,
   output logic [$clog2(MAX_OUTSTANDING):0]         outstanding
);

   localparam int unsigned BW_PERMIT = (BW_NODE_DATA + 7) / 8;
   localparam int unsigned BW_IDX    = $clog2(NUM_REQ);
`ifdef MUNOC_MOI_ARB_PRIORITY_EN
   localparam logic [NUM_REQ-1:0] RR_MASK = ~NUM_REQ'(1);
`else
   localparam logic [NUM_REQ-1:0] RR_MASK = '1;
`endif

   logic [BW_IDX-1:0]  ptr_q, ptr_d, hold_idx_q, hold_idx_d, win, cand_idx, head;
   logic               hold_q, hold_d, found, req_xfer, rsp_xfer, push, full, empty;
   logic [NUM_REQ-1:0] elig;
   int unsigned        cand;

   // Requesters that may be granted now: writers always, readers only with FIFO room.
   always_comb begin
      elig     = sqvalid & (sqwrite | {NUM_REQ{~full}});
      win      = hold_idx_q;
      found    = hold_q;
      cand     = 0;
      cand_idx = '0;
      if (!hold_q) begin
`ifdef MUNOC_MOI_ARB_PRIORITY_EN
         if (elig[0]) begin
            win   = '0;
            found = 1'b1;
         end
`endif
         for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = ptr_q + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            cand_idx = BW_IDX'(cand);
            if (!found && elig[cand_idx] && RR_MASK[cand_idx]) begin
               win   = cand_idx;
               found = 1'b1;
            end
         end
      end

      mqvalid   = 1'b0;
      mqaddr    = '0;
      mqwrite   = 1'b0;
      mqwdata   = '0;
      mqwpermit = '0;
      mqburden  = '0;
      sqdready  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (win == BW_IDX'(i)) begin
            mqvalid   = found & sqvalid[i];
            mqaddr    = sqaddr[i*BW_PLATFORM_ADDR +: BW_PLATFORM_ADDR];
            mqwrite   = sqwrite[i];
            mqwdata   = sqwdata[i*BW_NODE_DATA +: BW_NODE_DATA];
            mqwpermit = sqwpermit[i*BW_PERMIT +: BW_PERMIT];
            mqburden  = sqburden[i*BW_BURDEN_NZ +: BW_BURDEN_NZ];
            sqdready[2*i +: 2] = found ? mqdready : 2'b00;
         end
      end

      req_xfer   = mqvalid & mqdready[0];
      push       = req_xfer & ~mqwrite;
      hold_d     = mqvalid & ~mqdready[0];
      hold_idx_d = win;
      ptr_d      = ptr_q;
`ifdef MUNOC_MOI_ARB_PRIORITY_EN
      if (req_xfer && (win != '0)) ptr_d = BW_IDX'(rr_next_ptr(3'(win), NUM_REQ));
`else
      if (req_xfer) ptr_d = BW_IDX'(rr_next_ptr(3'(win), NUM_REQ));
`endif
   end

   // Response routing to the requester at the FIFO head.
   always_comb begin
      syvalid  = '0;
      mydready = 2'b00;
      syrdata  = myrdata;
      syburden = myburden;
      if (!empty) begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (head == BW_IDX'(i)) begin
               syvalid[i] = myvalid;
               mydready   = sydready[2*i +: 2];
            end
         end
      end
      rsp_xfer = myvalid & mydready[0];
   end

   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         ptr_q      <= '0;
         hold_q     <= 1'b0;
         hold_idx_q <= '0;
      end else begin
         ptr_q      <= ptr_d;
         hold_q     <= hold_d;
         hold_idx_q <= hold_idx_d;
      end
   end

   munoc_moi_order_fifo #(
      .WIDTH (BW_IDX),
      .DEPTH (MAX_OUTSTANDING)
   ) u_order_fifo (
      .clk       (clk),
      .rstnn     (rstnn),
      .push      (push),
      .push_data (win),
      .pop       (rsp_xfer),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .count     (outstanding)
   );

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (rstnn && myvalid && empty)
         $display("munoc_moi_request_arbiter: response with no pending read ignored at %0t", $time);
   end
`endif

endmodule
